// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Holds the FSM state encoding, default widths, the halt address, and the
// lookup-table label indices shared with the table contents and the assembler.
package pc_sequencer_pkg;

    localparam int unsigned PC_W    = 12;   // PC / branch-target width
    localparam int unsigned LUT_AW  = 5;    // lookup-table address width
    localparam int unsigned CYC_W   = 16;   // run-cycle counter width
    localparam int unsigned HALT_PC = 511;  // PC value that ends a run

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Branch label indices into the lookup table
    localparam logic [LUT_AW-1:0] LBL_LOOP = 5'd12;
    localparam logic [LUT_AW-1:0] LBL_EXIT = 5'd22;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and its surroundings (control, instruction
// fields, lookup table, status).
//   start, stall, abs_jump : run control and branch decode
//   lut_sel / lut_addr     : table select field in, table address out
//   lut_target             : absolute target returned by the table
//   prog_ctr, busy, done, pc_wrap, cycle_cnt : sequencer status
// The slave modport is the sequencer; master is the driving side.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned D  = PC_W,
    parameter int unsigned A  = LUT_AW,
    parameter int unsigned CW = CYC_W
) ();

    logic          start;
    logic          stall;
    logic          abs_jump;
    logic [A-1:0]  lut_sel;
    logic [A-1:0]  lut_addr;
    logic [D-1:0]  lut_target;
    logic [D-1:0]  prog_ctr;
    logic          busy;
    logic          done;
    logic          pc_wrap;
    logic [CW-1:0] cycle_cnt;

    modport slave (
        input  start, stall, abs_jump, lut_sel, lut_target,
        output lut_addr, prog_ctr, busy, done, pc_wrap, cycle_cnt
    );

    modport master (
        output start, stall, abs_jump, lut_sel, lut_target,
        input  lut_addr, prog_ctr, busy, done, pc_wrap, cycle_cnt
    );

endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable).
//   clk, rst_n : clock, async active-low reset
//   clr        : force count to zero on the next edge
//   en         : count up by one, sticking at all-ones
//   cnt        : registered count
module pc_sequencer_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage. Advances, jumps (via the
// combinational lookup table, zero-latency) or holds the PC each cycle and
// halts when the PC reaches the halt address.
//   clk, rst_n : clock, async active-low reset
//   bus        : pc_sequencer_if slave (control in, table access, status out)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned D       = PC_W,
    parameter int unsigned A       = LUT_AW,
    parameter int unsigned DONE_PC = HALT_PC,
    parameter int unsigned CW      = CYC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_sequencer_if.slave    bus
);

    state_t        state, state_nx;
    logic [D-1:0]  pc_q, pc_nx;
    logic          wrap_q, wrap_nx;
    logic          busy_q, done_q;
    logic          restart;
    logic          cnt_clr, cnt_en;
    logic [CW-1:0] cyc_cnt;
    logic [A-1:0]  sel;

    // Table address is a straight copy of the instruction select field
    assign sel          = bus.lut_sel;
    assign bus.lut_addr = sel;

    assign bus.prog_ctr  = pc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pc_wrap   = wrap_q;
    assign bus.cycle_cnt = cyc_cnt;

    // Next-state / next-PC: start > stall > abs_jump > increment
    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        wrap_nx  = wrap_q;
        restart  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        case (state)
            ST_IDLE, ST_HALT: begin
                restart = bus.start;
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (bus.start) begin
                    restart = 1'b1;
                end else if (!bus.stall) begin
                    if (bus.abs_jump) begin
                        pc_nx = bus.lut_target;
                    end else begin
                        pc_nx = pc_q + D'(1);
                        if (pc_q == {D{1'b1}}) begin
                            wrap_nx = 1'b1;
                        end
                    end
                    if (pc_nx == D'(DONE_PC)) begin
                        state_nx = ST_HALT;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (restart) begin
            state_nx = ST_RUN;
            pc_nx    = '0;
            wrap_nx  = 1'b0;
            cnt_clr  = 1'b1;
        end
    end

    // State and registered outputs; busy/done follow the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc_q   <= '0;
            wrap_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            pc_q   <= pc_nx;
            wrap_q <= wrap_nx;
            busy_q <= (state_nx == ST_RUN);
            done_q <= (state_nx == ST_HALT);
        end
    end

    pc_sequencer_sat_counter #(
        .W (CW)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cyc_cnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a reference model pushes expected
// outputs into a scoreboard queue as each cycle's stimulus is driven; they are
// popped and compared after the edge. A second instance with a 4-bit cycle
// counter shares the stimulus to exercise saturation.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int unsigned D   = 12;
    localparam int unsigned A   = 5;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW4 = 4;

    typedef struct {
        logic [11:0] pc;
        logic        busy;
        logic        done;
        logic        wrap;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.D(D), .A(A), .CW(CW))  bus  ();
    pc_sequencer_if #(.D(D), .A(A), .CW(CW4)) bus4 ();

    assign bus4.start      = bus.start;
    assign bus4.stall      = bus.stall;
    assign bus4.abs_jump   = bus.abs_jump;
    assign bus4.lut_sel    = bus.lut_sel;
    assign bus4.lut_target = bus.lut_target;

    pc_sequencer #(.D(D), .A(A), .DONE_PC(511), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pc_sequencer #(.D(D), .A(A), .DONE_PC(511), .CW(CW4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];

    // Reference model state: 0 idle, 1 run, 2 halt
    int          m_state;
    logic [11:0] m_pc;
    logic        m_wrap;
    logic [15:0] m_cnt;
    logic [3:0]  m_cnt4;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 12'h000;
        m_wrap  = 1'b0;
        m_cnt   = 16'h0000;
        m_cnt4  = 4'h0;
    endtask

    task automatic model_step(input logic st, input logic sl, input logic aj,
                              input logic [11:0] tgt);
        if (m_state == 1) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt4 != 4'hF)    m_cnt4 = m_cnt4 + 4'd1;
        end
        if (st) begin
            m_state = 1;
            m_pc    = 12'h000;
            m_wrap  = 1'b0;
            m_cnt   = 16'h0000;
            m_cnt4  = 4'h0;
        end else if (m_state == 1 && !sl) begin
            if (aj) begin
                m_pc = tgt;
            end else begin
                if (m_pc == 12'hFFF) m_wrap = 1'b1;
                m_pc = m_pc + 12'd1;
            end
            if (m_pc == 12'd511) m_state = 2;
        end
    endtask

    // One clock: drive, predict, push; after the edge pop and compare
    task automatic cycle(input logic st, input logic sl, input logic aj,
                         input logic [4:0] sel, input logic [11:0] tgt);
        exp_t e;
        bus.start      = st;
        bus.stall      = sl;
        bus.abs_jump   = aj;
        bus.lut_sel    = sel;
        bus.lut_target = tgt;
        #1;
        check("lut_addr", 32'(bus.lut_addr), 32'(sel));
        model_step(st, sl, aj, tgt);
        e.pc   = m_pc;
        e.busy = (m_state == 1);
        e.done = (m_state == 2);
        e.wrap = m_wrap;
        e.cnt  = m_cnt;
        e.cnt4 = m_cnt4;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("prog_ctr",  32'(bus.prog_ctr),   32'(e.pc));
        check("busy",      32'(bus.busy),       32'(e.busy));
        check("done",      32'(bus.done),       32'(e.done));
        check("pc_wrap",   32'(bus.pc_wrap),    32'(e.wrap));
        check("cycle_cnt", 32'(bus.cycle_cnt),  32'(e.cnt));
        check("cycle_cnt4", 32'(bus4.cycle_cnt), 32'(e.cnt4));
    endtask

    task automatic free_cycle();
        cycle(1'b0, 1'b0, 1'b0, 5'($urandom_range(0, 31)), 12'($urandom));
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.stall      = 1'b0;
        bus.abs_jump   = 1'b0;
        bus.lut_sel    = '0;
        bus.lut_target = '0;
        model_reset();

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",   32'(bus.prog_ctr),  32'h0);
        check("rst_busy", 32'(bus.busy),      32'h0);
        check("rst_done", 32'(bus.done),      32'h0);
        check("rst_cnt",  32'(bus.cycle_cnt), 32'h0);
        rst_n = 1'b1;

        // Idle ignores jump/stall
        cycle(1'b0, 1'b1, 1'b1, LBL_LOOP, 12'h123);
        check("idle_pc", 32'(bus.prog_ctr), 32'h0);

        // Run to 0x00D, then reset mid-cycle
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 12'h0);
        repeat (13) free_cycle();
        check("pre_rst_pc",   32'(bus.prog_ctr), 32'h00D);
        check("pre_rst_busy", 32'(bus.busy),     32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_pc",   32'(bus.prog_ctr),  32'h0);
        check("async_busy", 32'(bus.busy),      32'h0);
        check("async_done", 32'(bus.done),      32'h0);
        check("async_wrap", 32'(bus.pc_wrap),   32'h0);
        check("async_cnt",  32'(bus.cycle_cnt), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, LBL_LOOP, 12'h010);
        check("post_rst_busy", 32'(bus.busy),     32'h0);
        check("post_rst_pc",   32'(bus.prog_ctr), 32'h0);

        // Start and 8 free cycles
        cycle(1'b1, 1'b0, 1'b0, 5'd3, 12'h0);
        repeat (8) free_cycle();
        check("run8_pc",  32'(bus.prog_ctr),  32'h8);
        check("run8_cnt", 32'(bus.cycle_cnt), 32'h8);

        // Up to 0x014, stalled jump dropped, then taken jump
        repeat (12) free_cycle();
        check("at_014", 32'(bus.prog_ctr), 32'h014);
        cycle(1'b0, 1'b1, 1'b1, LBL_LOOP, 12'h010);
        check("stall_hold", 32'(bus.prog_ctr), 32'h014);
        cycle(1'b0, 1'b0, 1'b1, LBL_LOOP, 12'h010);
        check("jump_010", 32'(bus.prog_ctr), 32'h010);

        // Jump straight to halt; halt is frozen
        cycle(1'b0, 1'b0, 1'b1, LBL_EXIT, 12'd511);
        check("jhalt_pc",   32'(bus.prog_ctr), 32'd511);
        check("jhalt_done", 32'(bus.done),     32'h1);
        check("jhalt_busy", 32'(bus.busy),     32'h0);
        cycle(1'b0, 1'b0, 1'b1, LBL_LOOP, 12'h010);
        cycle(1'b0, 1'b1, 1'b0, LBL_LOOP, 12'h020);
        check("frozen_pc", 32'(bus.prog_ctr), 32'd511);

        // Sequential run into halt
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 12'h0);
        check("restart_pc",   32'(bus.prog_ctr),  32'h0);
        check("restart_done", 32'(bus.done),      32'h0);
        check("restart_cnt",  32'(bus.cycle_cnt), 32'h0);
        repeat (511) free_cycle();
        check("seq_halt_pc",   32'(bus.prog_ctr),  32'd511);
        check("seq_halt_done", 32'(bus.done),      32'h1);
        check("seq_halt_cnt",  32'(bus.cycle_cnt), 32'd511);
        check("seq_halt_cnt4", 32'(bus4.cycle_cnt), 32'd15);
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 12'h0);
        check("seq_restart_pc",   32'(bus.prog_ctr), 32'h0);
        check("seq_restart_done", 32'(bus.done),     32'h0);

        // Wrap through 0xFFF, sticky until start
        cycle(1'b0, 1'b0, 1'b1, 5'd7, 12'hFFF);
        free_cycle();
        check("wrap_pc",  32'(bus.prog_ctr), 32'h0);
        check("wrap_set", 32'(bus.pc_wrap),  32'h1);
        cycle(1'b0, 1'b0, 1'b1, LBL_EXIT, 12'd511);
        check("wrap_at_halt", 32'(bus.pc_wrap), 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 12'h0);
        check("wrap_clr", 32'(bus.pc_wrap), 32'h0);

        // 20-cycle run saturates the 4-bit counter
        repeat (20) free_cycle();
        check("sat_cnt4", 32'(bus4.cycle_cnt), 32'd15);
        check("sat_cnt",  32'(bus.cycle_cnt),  32'd20);

        // Wide start pulse keeps PC at 0
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 5'd1, 12'h0);
        check("wide_start_pc", 32'(bus.prog_ctr), 32'h0);

        // Jump to 0 is legal
        free_cycle();
        cycle(1'b0, 1'b0, 1'b1, 5'd31, 12'h000);
        check("jump_zero", 32'(bus.prog_ctr), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [11:0] tgt;
            case ($urandom_range(0, 5))
                0:       tgt = 12'd511;
                1:       tgt = 12'hFFF;
                default: tgt = 12'($urandom);
            endcase
            cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
